upsampler_cfg_loader: RTL and testbench

//  Boot-time configuration sequencer for the upsampler datapath. Takes a valid/ready word stream and

---
 rtl/upsampler_cfg_loader_if.sv | 12 +
 rtl/upsampler_cfg_loader.sv | 180 ++++++++++++++++++
 tb/tb_upsampler_cfg_loader.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/upsampler_cfg_loader_if.sv
// Valid/ready word stream that feeds configuration words into the loader.
// The producer uses the master side and the loader uses the slave side.
interface upsampler_cfg_loader_if #(
    parameter int S_DW = 64
);
    logic            s_valid;
    logic            s_ready;
    logic [S_DW-1:0] s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/upsampler_cfg_loader.sv
// Boot-time loader: streams words into the coefficient, vector-header and program RAMs in order,
// holds init while loading and pulses done once the core may run.
module upsampler_cfg_loader #(
    parameter int COE_AW  = 12,
    parameter int COE_DW  = 32,
    parameter int VECH_AW = 6,
    parameter int VECH_DW = 57,
    parameter int PROG_AW = 10,
    parameter int PROG_DW = 6,
    parameter int S_DW    = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [COE_AW:0]      n_coe,
    input  logic [VECH_AW:0]     n_vech,
    input  logic [PROG_AW:0]     n_prog,
    upsampler_cfg_loader_if.slave s,
    input  logic                 en_i,
    output logic                 core_en,
    output logic                 init,
    output logic                 coe_we,
    output logic [COE_AW-1:0]    coe_addr,
    output logic [COE_DW-1:0]    coe_wdata,
    output logic                 vech_we,
    output logic [VECH_AW-1:0]   vech_addr,
    output logic [VECH_DW-1:0]   vech_wdata,
    output logic                 prog_we,
    output logic [PROG_AW-1:0]   prog_addr,
    output logic [PROG_DW-1:0]   prog_wdata,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err
);
    localparam int MAX_AW = (COE_AW > VECH_AW) ? ((COE_AW > PROG_AW) ? COE_AW : PROG_AW)
                                               : ((VECH_AW > PROG_AW) ? VECH_AW : PROG_AW);
    localparam int CW = MAX_AW + 1;

    typedef enum logic [2:0] {S_IDLE, S_COE, S_VECH, S_PROG, S_FLUSH, S_DONE} state_t;

    state_t               state_reg, state_next;
    logic [COE_AW:0]      n_coe_reg;
    logic [VECH_AW:0]     n_vech_reg;
    logic [PROG_AW:0]     n_prog_reg;
    logic [CW-1:0]        cnt_reg, cnt_inc, sec_len;
    logic                 in_section, hs, last, oversize;
    logic                 coe_we_reg, vech_we_reg, prog_we_reg, done_reg, cfg_err_reg;
    logic [COE_AW-1:0]    coe_addr_reg;
    logic [COE_DW-1:0]    coe_wdata_reg;
    logic [VECH_AW-1:0]   vech_addr_reg;
    logic [VECH_DW-1:0]   vech_wdata_reg;
    logic [PROG_AW-1:0]   prog_addr_reg;
    logic [PROG_DW-1:0]   prog_wdata_reg;
    logic                 unused_bits;

    // A count is oversize when its MSB is set alongside any lower bit, i.e. above 2**AW.
    assign oversize = (n_coe[COE_AW]   && (n_coe[COE_AW-1:0]   != '0)) ||
                      (n_vech[VECH_AW] && (n_vech[VECH_AW-1:0] != '0)) ||
                      (n_prog[PROG_AW] && (n_prog[PROG_AW-1:0] != '0));

    assign in_section  = (state_reg == S_COE) || (state_reg == S_VECH) || (state_reg == S_PROG);
    assign hs          = in_section && s.s_valid;
    assign cnt_inc     = cnt_reg + CW'(1);
    assign last        = (cnt_inc == sec_len);
    assign unused_bits = ^s.s_data;

    always_comb begin
        sec_len = '0;
        case (state_reg)
            S_COE:   sec_len = CW'(n_coe_reg);
            S_VECH:  sec_len = CW'(n_vech_reg);
            S_PROG:  sec_len = CW'(n_prog_reg);
            default: sec_len = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            S_IDLE:
                if (start && !oversize) begin
                    if (n_coe != '0)       state_next = S_COE;
                    else if (n_vech != '0) state_next = S_VECH;
                    else if (n_prog != '0) state_next = S_PROG;
                    else                   state_next = S_DONE;
                end
            S_COE:
                if (abort) state_next = S_IDLE;
                else if (hs && last)
                    state_next = (n_vech_reg != '0) ? S_VECH :
                                 (n_prog_reg != '0) ? S_PROG : S_FLUSH;
            S_VECH:
                if (abort) state_next = S_IDLE;
                else if (hs && last) state_next = (n_prog_reg != '0) ? S_PROG : S_FLUSH;
            S_PROG:
                if (abort) state_next = S_IDLE;
                else if (hs && last) state_next = S_FLUSH;
            S_FLUSH: state_next = abort ? S_IDLE : S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // rst is folded into core_en so the controller is gated the instant reset asserts.
    always_comb begin
        busy      = (state_reg != S_IDLE);
        init      = (state_reg != S_IDLE);
        s.s_ready = in_section;
        core_en   = en_i && (state_reg == S_IDLE) && !rst;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_coe_reg      <= '0;
            n_vech_reg     <= '0;
            n_prog_reg     <= '0;
            cnt_reg        <= '0;
            coe_we_reg     <= 1'b0;
            vech_we_reg    <= 1'b0;
            prog_we_reg    <= 1'b0;
            done_reg       <= 1'b0;
            cfg_err_reg    <= 1'b0;
            coe_addr_reg   <= '0;
            coe_wdata_reg  <= '0;
            vech_addr_reg  <= '0;
            vech_wdata_reg <= '0;
            prog_addr_reg  <= '0;
            prog_wdata_reg <= '0;
        end else begin
            coe_we_reg  <= hs && (state_reg == S_COE);
            vech_we_reg <= hs && (state_reg == S_VECH);
            prog_we_reg <= hs && (state_reg == S_PROG);
            done_reg    <= (state_reg == S_DONE) && !abort;
            if ((state_reg == S_IDLE) && start) begin
                n_coe_reg   <= n_coe;
                n_vech_reg  <= n_vech;
                n_prog_reg  <= n_prog;
                cfg_err_reg <= oversize;
            end
            // Word index restarts at 0 for every section and whenever the load ends.
            if ((state_next == S_IDLE) || (hs && last)) cnt_reg <= '0;
            else if (hs)                                cnt_reg <= cnt_inc;
            if (hs) begin
                case (state_reg)
                    S_COE: begin
                        coe_addr_reg  <= cnt_reg[COE_AW-1:0];
                        coe_wdata_reg <= s.s_data[COE_DW-1:0];
                    end
                    S_VECH: begin
                        vech_addr_reg  <= cnt_reg[VECH_AW-1:0];
                        vech_wdata_reg <= s.s_data[VECH_DW-1:0];
                    end
                    S_PROG: begin
                        prog_addr_reg  <= cnt_reg[PROG_AW-1:0];
                        prog_wdata_reg <= s.s_data[PROG_DW-1:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    assign coe_we     = coe_we_reg;
    assign coe_addr   = coe_addr_reg;
    assign coe_wdata  = coe_wdata_reg;
    assign vech_we    = vech_we_reg;
    assign vech_addr  = vech_addr_reg;
    assign vech_wdata = vech_wdata_reg;
    assign prog_we    = prog_we_reg;
    assign prog_addr  = prog_addr_reg;
    assign prog_wdata = prog_wdata_reg;
    assign done       = done_reg;
    assign cfg_err    = cfg_err_reg;
endmodule

// File: tb/tb_upsampler_cfg_loader.sv
// Bench for upsampler_cfg_loader: word-index model of the load checked every cycle,
// plus directed literal checks of counts, timing, abort and reset behaviour.
`timescale 1ns/1ps
module tb_upsampler_cfg_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, abort = 1'b0, en_i = 1'b0;
    logic [12:0] n_coe = '0;
    logic [6:0]  n_vech = '0;
    logic [10:0] n_prog = '0;
    logic        core_en, init, coe_we, vech_we, prog_we, busy, done, cfg_err;
    logic [11:0] coe_addr;
    logic [31:0] coe_wdata;
    logic [5:0]  vech_addr;
    logic [56:0] vech_wdata;
    logic [9:0]  prog_addr;
    logic [5:0]  prog_wdata;

    upsampler_cfg_loader_if #(.S_DW(64)) s_if();

    upsampler_cfg_loader dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .n_coe(n_coe), .n_vech(n_vech), .n_prog(n_prog), .s(s_if), .en_i(en_i),
        .core_en(core_en), .init(init),
        .coe_we(coe_we), .coe_addr(coe_addr), .coe_wdata(coe_wdata),
        .vech_we(vech_we), .vech_addr(vech_addr), .vech_wdata(vech_wdata),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int     n_checks = 0, n_errors = 0;
    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: the k-th accepted word of a load goes to coe[k], then vech[k-nc], then prog[k-nc-nv].
    bit          m_active = 0, m_err = 0, m_done = 0;
    int          m_tail = 0, m_acc = 0, m_total = 0, m_nc = 0, m_nv = 0;
    bit          p_valid = 0;
    int          p_sec = 0, p_addr = 0;
    logic [63:0] p_data = '0;

    always @(negedge clk) begin : compare
        bit eb, dn, over;
        int k;
        if (rst) begin
            m_active = 0; m_err = 0; m_done = 0; m_tail = 0; m_acc = 0; p_valid = 0;
        end else begin
            eb = m_active || (m_tail > 0);
            chk("busy", busy, eb);
            chk("init", init, eb);
            chk("s_ready", s_if.s_ready, m_active);
            chk("core_en", core_en, en_i && !eb);
            chk("done", done, m_done);
            chk("cfg_err", cfg_err, m_err);
            chk("coe_we", coe_we, p_valid && p_sec == 0);
            chk("vech_we", vech_we, p_valid && p_sec == 1);
            chk("prog_we", prog_we, p_valid && p_sec == 2);
            if (p_valid && p_sec == 0) begin
                chk("coe_addr", coe_addr, p_addr);
                chk("coe_wdata", coe_wdata, p_data[31:0]);
            end
            if (p_valid && p_sec == 1) begin
                chk("vech_addr", vech_addr, p_addr);
                chk("vech_wdata", vech_wdata, p_data[56:0]);
            end
            if (p_valid && p_sec == 2) begin
                chk("prog_addr", prog_addr, p_addr);
                chk("prog_wdata", prog_wdata, p_data[5:0]);
            end
            dn = 0;
            if (m_tail > 0) begin
                m_tail--;
                if (m_tail == 0) dn = 1;
            end
            p_valid = 0;
            if (m_active && s_if.s_valid) begin
                k = m_acc;
                p_valid = 1;
                p_data = s_if.s_data;
                if (k < m_nc)             begin p_sec = 0; p_addr = k; end
                else if (k < m_nc + m_nv) begin p_sec = 1; p_addr = k - m_nc; end
                else                      begin p_sec = 2; p_addr = k - m_nc - m_nv; end
                m_acc++;
                if (m_acc == m_total) begin m_active = 0; m_tail = 2; end
            end
            if (abort && eb) begin m_active = 0; m_tail = 0; dn = 0; end
            if (start && !eb) begin
                over = (n_coe > 4096) || (n_vech > 64) || (n_prog > 1024);
                m_err = over;
                if (!over) begin
                    m_nc = int'(n_coe); m_nv = int'(n_vech);
                    m_total = int'(n_coe) + int'(n_vech) + int'(n_prog);
                    m_acc = 0;
                    if (m_total > 0) m_active = 1;
                    else             m_tail = 1;
                end
            end
            m_done = dn;
        end
    end

    // Observed write log for the directed literal checks.
    int          st_coe = 0, st_vech = 0, st_prog = 0, st_done = 0;
    longint      last_wr = 0, done_cyc = 0, start_cyc = 0;
    logic [31:0] mem_coe [0:4095];
    logic [56:0] mem_vech [0:63];
    logic [5:0]  mem_prog [0:1023];

    always @(negedge clk) begin
        if (!rst) begin
            if (coe_we)  begin st_coe++;  mem_coe[coe_addr] = coe_wdata;    last_wr = cyc; end
            if (vech_we) begin st_vech++; mem_vech[vech_addr] = vech_wdata; last_wr = cyc; end
            if (prog_we) begin st_prog++; mem_prog[prog_addr] = prog_wdata; last_wr = cyc; end
            if (done)    begin st_done++; done_cyc = cyc; end
        end
    end

    task automatic clr_stats();
        st_coe = 0; st_vech = 0; st_prog = 0; st_done = 0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int nc, input int nv, input int np);
        n_coe = 13'(nc); n_vech = 7'(nv); n_prog = 11'(np);
        start = 1'b1;
        @(negedge clk);
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Presents words first..first+n-1; with toggle, s_valid drops every other cycle.
    task automatic send(input int n, input logic [63:0] first, input bit toggle);
        int i = 0;
        int guard = 0;
        while (i < n && guard < 200) begin
            if (toggle && (guard % 2 == 1)) s_if.s_valid = 1'b0;
            else begin
                s_if.s_valid = 1'b1;
                s_if.s_data  = first + 64'(i);
            end
            @(negedge clk);
            if (s_if.s_valid && s_if.s_ready) i++;
            @(posedge clk); #1;
            guard++;
        end
        s_if.s_valid = 1'b0;
        chk("send_words_accepted", i, n);
    endtask

    initial begin
        s_if.s_valid = 1'b0;
        s_if.s_data  = '0;
        wait_cycles(3);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_coe_addr", coe_addr, 0);
        chk("rst_s_ready", s_if.s_ready, 0);
        chk("rst_core_en", core_en, 0);
        @(posedge clk); #1;
        en_i = 1'b1;

        // Full load 3/2/1 back-to-back
        clr_stats();
        do_start(3, 2, 1);
        send(6, 64'h11, 0);
        wait_cycles(5);
        chk("t1_coe_writes", st_coe, 3);
        chk("t1_vech_writes", st_vech, 2);
        chk("t1_prog_writes", st_prog, 1);
        chk("t1_done_pulses", st_done, 1);
        chk("t1_done_latency", done_cyc - last_wr, 2);
        chk("t1_coe0", mem_coe[0], 32'h11);
        chk("t1_coe2", mem_coe[2], 32'h13);
        chk("t1_vech1", mem_vech[1], 57'h15);
        chk("t1_prog0", mem_prog[0], 6'h16);

        // Program-only load
        clr_stats();
        do_start(0, 0, 2);
        send(2, 64'h21, 0);
        wait_cycles(5);
        chk("t2_coe_writes", st_coe, 0);
        chk("t2_vech_writes", st_vech, 0);
        chk("t2_prog_writes", st_prog, 2);
        chk("t2_prog1", mem_prog[1], 6'h22);
        chk("t2_done_pulses", st_done, 1);

        // Empty load
        clr_stats();
        do_start(0, 0, 0);
        wait_cycles(4);
        chk("t3_done_pulses", st_done, 1);
        chk("t3_done_latency", done_cyc - start_cyc, 2);
        chk("t3_strobes", st_coe + st_vech + st_prog, 0);

        // Oversize vector-header count
        clr_stats();
        do_start(1, 65, 1);
        @(negedge clk);
        chk("t4_cfg_err_set", cfg_err, 1);
        chk("t4_busy", busy, 0);
        wait_cycles(3);
        chk("t4_strobes", st_coe + st_vech + st_prog, 0);
        chk("t4_done_pulses", st_done, 0);
        do_start(0, 0, 0);
        @(negedge clk);
        chk("t4_cfg_err_clear", cfg_err, 0);
        wait_cycles(3);

        // Gapped stream
        clr_stats();
        do_start(4, 0, 0);
        send(4, 64'h41, 1);
        wait_cycles(5);
        chk("t5_coe_writes", st_coe, 4);
        chk("t5_coe3", mem_coe[3], 32'h44);
        chk("t5_done_pulses", st_done, 1);

        // Abort after the second coefficient
        clr_stats();
        do_start(5, 0, 0);
        send(2, 64'h51, 0);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("t6_busy_after_abort", busy, 0);
        wait_cycles(5);
        chk("t6_coe_writes", st_coe, 2);
        chk("t6_done_pulses", st_done, 0);

        // Reset in the middle of the vector-header section
        clr_stats();
        do_start(1, 3, 0);
        send(2, 64'h61, 0);
        s_if.s_valid = 1'b1;
        s_if.s_data  = 64'h63;
        @(negedge clk);
        chk("t7_core_en_gated", core_en, 0);
        chk("t7_vech_we_before", vech_we, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("t7_busy", busy, 0);
        chk("t7_init", init, 0);
        chk("t7_s_ready", s_if.s_ready, 0);
        chk("t7_core_en", core_en, 0);
        chk("t7_we", {coe_we, vech_we, prog_we}, 0);
        chk("t7_vech_addr", vech_addr, 0);
        chk("t7_done", done, 0);
        s_if.s_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;

        // Reload after reset
        clr_stats();
        do_start(1, 1, 1);
        send(3, 64'h71, 0);
        wait_cycles(5);
        chk("t8_writes", st_coe + st_vech + st_prog, 3);
        chk("t8_done_pulses", st_done, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
